// File: rtl/mult_arbiter_if.sv
// Signal bundle between mult_arbiter, its requesters, the result consumer and the shared multiplier.
// The master modport is the arbiter's view; the slave modport is everything around it.
interface mult_arbiter_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int N_REQ        = 4,
    parameter int ID_BITS      = 2
);
    logic [N_REQ-1:0]              REQ_VALID_I;
    logic [N_REQ-1:0]              REQ_READY_O;
    logic [N_REQ*PAYLOAD_BITS-1:0] REQ_A_I;
    logic [N_REQ*PAYLOAD_BITS-1:0] REQ_B_I;
    logic                          MULT_LOAD_O;
    logic [PAYLOAD_BITS-1:0]       MULT_A_O;
    logic [PAYLOAD_BITS-1:0]       MULT_B_O;
    logic [2*PAYLOAD_BITS-1:0]     MULT_DATA_I;
    logic                          RES_VALID_O;
    logic                          RES_READY_I;
    logic [ID_BITS-1:0]            RES_ID_O;
    logic [2*PAYLOAD_BITS-1:0]     RES_DATA_O;
    logic                          BUSY_O;

    modport master (
        input  REQ_VALID_I, REQ_A_I, REQ_B_I, MULT_DATA_I, RES_READY_I,
        output REQ_READY_O, MULT_LOAD_O, MULT_A_O, MULT_B_O,
               RES_VALID_O, RES_ID_O, RES_DATA_O, BUSY_O
    );

    modport slave (
        output REQ_VALID_I, REQ_A_I, REQ_B_I, MULT_DATA_I, RES_READY_I,
        input  REQ_READY_O, MULT_LOAD_O, MULT_A_O, MULT_B_O,
               RES_VALID_O, RES_ID_O, RES_DATA_O, BUSY_O
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin controller sharing one fixed-latency multiplier between N_REQ requesters.
// Optional macro MULT_ARB_STATS_EN adds result/stall counters (OPS_CNT_O, STALL_CNT_O).
module mult_arbiter #(
    parameter int PAYLOAD_BITS = 8,
    parameter int N_REQ        = 4,
    parameter int ID_BITS      = 2,
    parameter int MULT_LAT     = 3
) (
    input  logic           CLK_I,
    input  logic           RST_N_I,
    mult_arbiter_if.master arb_if
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [15:0]    OPS_CNT_O,
    output logic [15:0]    STALL_CNT_O
`endif
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam int         CNT_BITS = $clog2(MULT_LAT + 1);

    logic [1:0]                state_q;
    logic [ID_BITS-1:0]        ptr_q;
    logic [ID_BITS-1:0]        res_id_q;
    logic [CNT_BITS-1:0]       cnt_q;
    logic                      res_valid_q;
    logic [2*PAYLOAD_BITS-1:0] res_data_q;

    logic                      found_hi, found_lo;
    logic [ID_BITS-1:0]        id_hi, id_lo;
    logic                      grant_found;
    logic [ID_BITS-1:0]        grant_id;
    logic                      accept;
    logic                      res_fire;
    logic [N_REQ-1:0]          ready_oh;
    logic [PAYLOAD_BITS-1:0]   sel_a, sel_b;

    // Round robin: first valid at or above the pointer, else the lowest valid overall.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        id_hi    = '0;
        id_lo    = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (arb_if.REQ_VALID_I[j]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    id_lo    = ID_BITS'(j);
                end
                if (!found_hi && (j >= int'(ptr_q))) begin
                    found_hi = 1'b1;
                    id_hi    = ID_BITS'(j);
                end
            end
        end
        grant_found = found_lo;
        grant_id    = found_hi ? id_hi : id_lo;
    end

    // Reset gates acceptance so nothing is loaded into the multiplier while RST_N_I is low.
    assign accept   = RST_N_I && (state_q == ST_IDLE) && grant_found;
    assign res_fire = res_valid_q && arb_if.RES_READY_I;

    always_comb begin
        ready_oh = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (accept && (grant_id == ID_BITS'(j))) begin
                ready_oh[j] = 1'b1;
                sel_a       = arb_if.REQ_A_I[j*PAYLOAD_BITS +: PAYLOAD_BITS];
                sel_b       = arb_if.REQ_B_I[j*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign arb_if.REQ_READY_O = ready_oh;
    assign arb_if.MULT_LOAD_O = accept;
    assign arb_if.MULT_A_O    = sel_a;
    assign arb_if.MULT_B_O    = sel_b;
    assign arb_if.RES_VALID_O = res_valid_q;
    assign arb_if.RES_ID_O    = res_id_q;
    assign arb_if.RES_DATA_O  = res_data_q;
    assign arb_if.BUSY_O      = (state_q != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        res_id_q <= grant_id;
                        ptr_q    <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_BITS'(1);
                        cnt_q    <= CNT_BITS'(MULT_LAT);
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The product is valid during the cycle where the counter reads 1.
                    cnt_q <= cnt_q - CNT_BITS'(1);
                    if (cnt_q == CNT_BITS'(1)) begin
                        res_data_q  <= arb_if.MULT_DATA_I;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_fire) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [15:0] ops_q;
    logic [15:0] stall_q;

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            if (res_fire) begin
                ops_q <= ops_q + 16'd1;
            end
            if ((state_q == ST_RESP) && !arb_if.RES_READY_I && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign OPS_CNT_O   = ops_q;
    assign STALL_CNT_O = stall_q;
`endif
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin controller that shares one non-pipelined shift-add multiplier (`mult`) between N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's `LOAD_I` and operand inputs.
- Waits the multiplier's fixed latency, captures the product and returns it tagged with the requester ID over a backpressured result handshake.
- Sits between client engines and the single `mult` instance; exactly one operation is in flight at a time.

Parameters:
- `PAYLOAD_BITS`, 8: operand width; the product is 2*PAYLOAD_BITS wide. Must match the `mult` instance.
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_BITS`, 2: width of the requester ID, at least ceil(log2(N_REQ)).
- `MULT_LAT`, 3: cycles after the load cycle until the product on `MULT_DATA_I` is valid; the capture happens at the end of cycle T+MULT_LAT. Minimum 1.

Ports:
- `CLK_I`  in  1  clock
- `RST_N_I`  in  1  reset
- `REQ_VALID_I`  in  N_REQ  per-requester operand-pair valid
- `REQ_READY_O`  out  N_REQ  per-requester accept; one-hot or zero
- `REQ_A_I`  in  N_REQ*PAYLOAD_BITS  operand one; requester i occupies slice [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- `REQ_B_I`  in  N_REQ*PAYLOAD_BITS  operand two; same slicing as `REQ_A_I`
- `MULT_LOAD_O`  out  1  drives `mult.LOAD_I`
- `MULT_A_O`  out  PAYLOAD_BITS  drives `mult.OPER_ONE_I`
- `MULT_B_O`  out  PAYLOAD_BITS  drives `mult.OPER_TWO_I`
- `MULT_DATA_I`  in  2*PAYLOAD_BITS  from `mult.DATA_O`
- `RES_VALID_O`  out  1  result valid
- `RES_READY_I`  in  1  result consumer ready
- `RES_ID_O`  out  ID_BITS  index of the requester that issued the operation
- `RES_DATA_O`  out  2*PAYLOAD_BITS  product
- `BUSY_O`  out  1  high when the state is not IDLE

Behaviour:
- Reset: `RST_N_I` is asynchronous, active-low; clock is `CLK_I`.
  - State = IDLE, round-robin pointer = 0, wait counter = 0.
  - `RES_VALID_O`, `RES_ID_O`, `RES_DATA_O`, `BUSY_O` = 0.
  - `MULT_LOAD_O` = 0; `MULT_A_O`, `MULT_B_O` = 0.
  - Reset asserted mid-operation aborts the operation: no result is produced, and the `mult` output is ignored until a new load.
- IDLE:
  - Winner = the first requester i with `REQ_VALID_I[i]` = 1, scanning from the pointer upward modulo N_REQ.
  - In the same cycle, combinationally: `REQ_READY_O[winner]` = 1; `MULT_LOAD_O` = 1; `MULT_A_O`/`MULT_B_O` = the winner's operands. Register the winner ID.
  - Pointer becomes (winner+1) mod N_REQ, and the state goes to WAIT with the counter = MULT_LAT.
  - With no valid request: `REQ_READY_O` = 0 and `MULT_LOAD_O` = 0.
- WAIT:
  - `MULT_LOAD_O` = 0 throughout. The multiplier stalls if LOAD is high, so LOAD must never pulse during WAIT.
  - `REQ_READY_O` = 0; the counter decrements each cycle.
  - When the counter reaches 1, capture `MULT_DATA_I` into `RES_DATA_O` at that edge, set `RES_VALID_O` = 1 and go to RESP. For a load in cycle T, `RES_VALID_O` is first high in cycle T+MULT_LAT+1.
- RESP:
  - `RES_VALID_O`, `RES_ID_O` and `RES_DATA_O` are held stable until `RES_VALID_O` && `RES_READY_I`.
  - On that handshake, clear `RES_VALID_O` and go to IDLE. The next acceptance is possible in the following cycle, giving a minimum issue period of MULT_LAT+2 cycles.
  - `REQ_READY_O` = 0 during RESP.
- Requesters:
  - A requester must hold valid and operands stable until it sees ready; requests are not dropped.
  - Deasserting valid before it is accepted is allowed; that requester is then skipped.
- Fairness: every continuously-valid requester is granted within N_REQ grants.
- Width: the product is taken unmodified from `MULT_DATA_I`; the controller performs no arithmetic.
- `BUSY_O` = 1 in WAIT and RESP.

Optional Feature:
- Macro `MULT_ARB_STATS_EN`.
- Defined:
  - Adds output `OPS_CNT_O`, 16 bits. It increments on each result handshake and wraps 0xFFFF→0.
  - Adds output `STALL_CNT_O`, 16 bits. It increments on each RESP cycle with `RES_READY_I` = 0 and saturates at 0xFFFF.
  - Both counters reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
1. Single request: requester 2 sends A=0x0C, B=0x0B with `RES_READY_I` = 1 → `REQ_READY_O` = 0b0100 in the accept cycle; `MULT_LOAD_O` is high for exactly 1 cycle; `RES_VALID_O` rises 4 cycles later with ID=2, DATA=0x0084.
2. All 4 requesters valid continuously, pointer 0 → grant order 0,1,2,3,0; product 0xFF*0xFF=0xFE01 is returned to the correct ID on each grant.
3. Backpressure: `RES_READY_I` = 0 for 10 cycles during RESP → `RES_VALID_O`, `RES_ID_O` and `RES_DATA_O` are held stable; `REQ_READY_O` stays 0; the result is released on the first ready cycle, with `STALL_CNT_O` = 10 when `MULT_ARB_STATS_EN` is defined.
4. Reset asserted in the 2nd WAIT cycle → all outputs are 0 immediately; after release, no result appears; a new request 0x03*0x05 returns 0x000F.
5. Requester 1 valid for 1 cycle while the block is in WAIT, then deasserted; requester 3 stays valid → the next grant goes to 3, and 1 is never acknowledged.
6. Operands 0x00*0xA5 and 0x80*0x02 → DATA is 0x0000 and 0x0100 respectively; `OPS_CNT_O` increments by 2.
